// File: rtl/operand_buffer.sv
// Word-addressed staging memory for the systolic array: 32-bit STORE in, 64-bit pair STREAM/READ out.
// Optional feature macro: BUFFER_ZERO_PAD_EN (STREAM with one word left emits it zero-padded).
module operand_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          state,
    output logic [2*DATA_W-1:0] data_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned OUT_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_STORE  = 2'b01,
        CMD_STREAM = 2'b10,
        CMD_READ   = 2'b11
    } cmd_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [OUT_W-1:0]  data_out_nxt;
    logic              mem_we_c;

    cmd_t              cmd_c;
    logic [ADDR_W-1:0] rd_lo_c;
    logic [ADDR_W-1:0] rd_hi_c;
    logic [DATA_W-1:0] word_lo_c;
    logic [DATA_W-1:0] word_hi_c;
    logic              full_c;

    assign cmd_c = cmd_t'(state);

    // READ uses the external address; everything else reads at the stream pointer
    assign rd_lo_c   = (cmd_c == CMD_READ) ? addr : rd_ptr;
    assign rd_hi_c   = ADDR_W'(rd_lo_c + ADDR_W'(1));
    assign word_lo_c = mem[rd_lo_c];
    assign word_hi_c = mem[rd_hi_c];
    assign full_c    = (count == CNT_W'(DEPTH));

    // Next-state and output decode
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        data_out_nxt = data_out;
        mem_we_c     = 1'b0;

        case (cmd_c)
            CMD_IDLE: begin
            end
            CMD_STORE: begin
                if (!full_c) begin
                    mem_we_c   = rst;
                    wr_ptr_nxt = ADDR_W'(wr_ptr + ADDR_W'(1));
                    count_nxt  = CNT_W'(count + CNT_W'(1));
                end
            end
            CMD_STREAM: begin
                if (count >= CNT_W'(2)) begin
                    data_out_nxt = {word_hi_c, word_lo_c};
                    rd_ptr_nxt   = ADDR_W'(rd_ptr + ADDR_W'(2));
                    count_nxt    = CNT_W'(count - CNT_W'(2));
                end
`ifdef BUFFER_ZERO_PAD_EN
                else if (count == CNT_W'(1)) begin
                    data_out_nxt = {DATA_W'(0), word_lo_c};
                    rd_ptr_nxt   = ADDR_W'(rd_ptr + ADDR_W'(1));
                    count_nxt    = '0;
                end
`endif
            end
            CMD_READ: begin
                data_out_nxt = {word_hi_c, word_lo_c};
            end
            default: begin
            end
        endcase
    end

    // Control state and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            data_out <= data_out_nxt;
        end
    end

    // Storage is never reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_operand_buffer.sv
// Randomized bench for operand_buffer against a FIFO-plus-array reference model.
module tb_operand_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned OUT_W  = 2 * DATA_W;

    localparam logic [1:0] C_IDLE   = 2'b00;
    localparam logic [1:0] C_STORE  = 2'b01;
    localparam logic [1:0] C_STREAM = 2'b10;
    localparam logic [1:0] C_READ   = 2'b11;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        state;
    logic [OUT_W-1:0]  data_out;

    operand_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .addr     (addr),
        .state    (state),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending words as a FIFO, storage as a plain array
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] pending [$];
    int unsigned       ref_wr;
    logic [OUT_W-1:0]  exp_out;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic [1:0] cmd, input logic [DATA_W-1:0] d, input int unsigned a);
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        case (cmd)
            C_STORE: begin
                if (pending.size() < DEPTH) begin
                    ref_mem[ref_wr] = d;
                    ref_wr = (ref_wr + 1) % DEPTH;
                    pending.push_back(d);
                end
            end
            C_STREAM: begin
                if (pending.size() >= 2) begin
                    lo = pending.pop_front();
                    hi = pending.pop_front();
                    exp_out = {hi, lo};
                end
`ifdef BUFFER_ZERO_PAD_EN
                else if (pending.size() == 1) begin
                    lo = pending.pop_front();
                    exp_out = {32'h0, lo};
                end
`endif
            end
            C_READ: exp_out = {ref_mem[(a + 1) % DEPTH], ref_mem[a]};
            default: begin
            end
        endcase
    endtask

    // One command: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic do_cmd(input string tag, input logic [1:0] cmd, input logic [DATA_W-1:0] d,
                          input int unsigned a);
        @(negedge clk);
        state   = cmd;
        data_in = d;
        addr    = ADDR_W'(a);
        @(posedge clk);
        model_step(cmd, d, a);
        #1;
        check(tag, data_out, exp_out);
    endtask

    // Asynchronous reset pulse, checked before any clock edge
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        state = C_IDLE;
        #2;
        rst = 1'b0;
        #1;
        pending.delete();
        ref_wr  = 0;
        exp_out = '0;
        check(tag, data_out, exp_out);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int unsigned r;
        int unsigned stores;
        logic [OUT_W-1:0] held;

        n_checks = 0;
        n_fail   = 0;
        ref_wr   = 0;
        exp_out  = '0;
        rst      = 1'b0;
        state    = C_IDLE;
        data_in  = '0;
        addr     = '0;

        #3;
        check("reset_out", data_out, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_cmd("store0", C_STORE, 32'hDEADBEEF, 0);
        do_cmd("store1", C_STORE, 32'hCAFEBABE, 0);
        do_cmd("stream_pair", C_STREAM, '0, 0);
        check("stream_pair_const", data_out, 64'hCAFEBABE_DEADBEEF);
        do_cmd("stream_empty", C_STREAM, '0, 0);
        check("stream_empty_hold", data_out, 64'hCAFEBABE_DEADBEEF);

        pulse_reset("async_reset");

        do_cmd("store_after_rst", C_STORE, 32'hAABBCCDD, 0);
        do_cmd("read_retained", C_READ, '0, 0);
        check("read_retained_const", data_out, 64'hCAFEBABE_AABBCCDD);
        do_cmd("stream_single", C_STREAM, '0, 0);
`ifdef BUFFER_ZERO_PAD_EN
        check("stream_single_const", data_out, 64'h00000000_AABBCCDD);
`else
        check("stream_single_const", data_out, 64'hCAFEBABE_AABBCCDD);
`endif
        do_cmd("idle_hold", C_IDLE, 32'h11111111, 5);

        // Fill the whole buffer with data equal to the index, then overflow
        pulse_reset("reset_before_fill");
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd("fill", C_STORE, DATA_W'(i), 0);
        end
        do_cmd("store_full", C_STORE, 32'h12345678, 0);
        do_cmd("read_wrap", C_READ, '0, DEPTH - 1);
        check("read_wrap_const", data_out, {32'h0, DATA_W'(DEPTH - 1)});
        do_cmd("read_zero", C_READ, '0, 0);
        do_cmd("stream_after_full", C_STREAM, '0, 0);
        check("stream_after_full_const", data_out, {32'h1, 32'h0});
        do_cmd("store_refill", C_STORE, 32'h0BADF00D, 0);
        do_cmd("read_refill", C_READ, '0, DEPTH - 1);
        check("read_refill_const", data_out, {32'h0BADF00D, DATA_W'(DEPTH - 1)});

        // Random mix driven past a write-pointer wrap
        pulse_reset("reset_before_random");
        stores = 0;
        while (stores < DEPTH + 600) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_cmd("rand_idle", C_IDLE, $urandom, $urandom_range(0, DEPTH - 1));
            end else if (r <= 5) begin
                stores++;
                do_cmd("rand_store", C_STORE, $urandom, 0);
            end else if (r <= 8) begin
                do_cmd("rand_stream", C_STREAM, $urandom, 0);
            end else begin
                do_cmd("rand_read", C_READ, '0, $urandom_range(0, DEPTH - 1));
            end
        end

        // Drain: every remaining pair must come out in write order
        while (pending.size() >= 2) begin
            do_cmd("drain", C_STREAM, '0, 0);
        end
        held = exp_out;
        do_cmd("drain_tail", C_STREAM, '0, 0);
        if (pending.size() == 0) begin
            do_cmd("drain_done", C_STREAM, '0, 0);
            check("drain_done_hold", data_out, held);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
